sar_cap_sequencer: RTL and testbench
====================================

# sar_cap_sequencer

Successive-approximation sequencer for the 16-bit capacitor DAC array. It runs the sampling phase, then walks the 16 bottom-plate controls MSB to LSB, handshaking with the comparator once per bit. It returns the final code and sits between the ADC top-level control and the analog array/comparator black boxes. The top plate is analog and not touched by this block.

## Interface
Parameters:
- SAMPLE_CYCLES, 4: cycles samp_en is held high (≥1)
- SETTLE_CYCLES, 1: DAC settle cycles before each comparison (≥1)
- TIMEOUT_CYCLES, 8: WAIT cycles without comp_valid before forced decision (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  conversion request; accepted only in IDLE
- abort  in  1  synchronous abort; highest priority after reset
- samp_en  out  1  sampling switch enable
- comp_start  out  1  one-cycle comparator strobe
- comp_valid  in  1  comparator decision valid
- comp_out  in  1  decision: 1 = keep trial bit, 0 = clear it
- cap_botplate  out  16  bottom-plate control bus to array
- result  out  16  last completed code
- done  out  1  one-cycle pulse, result updated
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky: a decision was forced by timeout

## Operation
- Reset values: samp_en=0, comp_start=0, cap_botplate=0x0000, result=0x0000, done=0, busy=0, timeout_err=0; state IDLE.
- States: IDLE, SAMPLE, SETTLE, COMP, WAIT, DONE. Bit index i is 4 bits and starts at 15.
- IDLE: cap_botplate=0. If start=1, go to SAMPLE, clear timeout_err, and load the sample counter.
- SAMPLE: samp_en=1 for exactly SAMPLE_CYCLES cycles. On exit, cap_botplate=0x8000 (trial bit 15), i=15, go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to COMP.
- COMP: comp_start=1 for one cycle, then go to WAIT. comp_valid is ignored in COMP.
- WAIT on comp_valid=1:
  - Set cap_botplate[i]=comp_out.
  - If i>0: set cap_botplate[i-1]=1 in the same edge, decrement i, go to SETTLE.
  - If i=0: result gets the final bus value, go to DONE.
- WAIT timeout: after TIMEOUT_CYCLES cycles without comp_valid, the decision is forced to 0 and timeout_err is set. Processing then continues as for a normal decision.
- DONE: done=1 for one cycle, then IDLE. The bus returns to 0x0000 on entry to IDLE.
- Ignored inputs: start outside IDLE, including in the DONE cycle. comp_valid outside WAIT.
- abort=1 in any non-IDLE state:
  - Next state IDLE, cap_botplate=0, samp_en=0.
  - No done pulse; result and timeout_err unchanged.
  - start and abort both high in IDLE: abort wins, so start is not accepted.
- Asynchronous reset mid-conversion returns all outputs to reset values immediately.

## Timing
- All outputs are registered.
- Cycle numbering: start is sampled high in cycle 0.
  - samp_en is high in cycles 1..SAMPLE_CYCLES.
  - Each bit costs SETTLE_CYCLES+1+w cycles, where w ≥ 1 is the number of WAIT cycles up to and including the comp_valid cycle.
- Defaults with comp_valid in the first WAIT cycle: samp_en cycles 1–4; bit 15 occupies SETTLE 5, COMP 6, WAIT 7; done in cycle 53; busy in cycles 1–53.
- The new cap_botplate value is visible in the cycle after the decision edge.
- Timeout: a silent comparator adds TIMEOUT_CYCLES per bit.

## Test plan
- Comparator model returns the bits of 0xA5C3 MSB-first, with comp_valid one cycle after comp_start. Required: result=0xA5C3 and done high in cycle 53 (defaults). cap_botplate must read 0x8000 in cycle 5, then 0xC000 after the bit-15 decision of 1.
- All decisions 0 gives result=0x0000. All decisions 1 gives result=0xFFFF. Also check trial bus values 0x8000…0x0001 and 0xFFFF before the final decision.
- comp_valid delayed 3 WAIT cycles per bit gives done in cycle 85. start pulses while busy and in the DONE cycle are ignored: exactly one done pulse.
- comp_valid never asserted, TIMEOUT_CYCLES=8. Required: result=0x0000, timeout_err=1 at done, and timeout_err cleared at the next accepted start.
- abort in cycle 20. Required: busy=0 and cap_botplate=0 in cycle 21, no done pulse, result keeps the previous 0xA5C3.
- rst_n low in cycle 30 of a conversion. Required: all outputs return to reset values immediately. A new start after release converts correctly.

Source files
------------

// File: rtl/sar_cap_sequencer.sv
// ---------------------------------------------------------------------------
// sar_cap_sequencer
//
// Successive-approximation sequencer for a 16-bit capacitor DAC array.
// Runs the sampling phase, then walks the bottom-plate controls MSB to LSB.
// For each bit it lets the DAC settle, strobes the comparator and waits for
// its decision. A silent comparator is covered by a per-bit timeout that
// forces the decision to 0. The top plate is analog and not driven here.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   conversion request, accepted only in IDLE
//   abort         in   synchronous abort, wins over everything but reset
//   samp_en       out  sampling switch enable
//   comp_start    out  one-cycle comparator strobe
//   comp_valid    in   comparator decision valid (looked at only in WAIT)
//   comp_out      in   decision: 1 = keep trial bit, 0 = clear it
//   cap_botplate  out  [15:0] bottom-plate control bus
//   result        out  [15:0] last completed code
//   done          out  one-cycle pulse when result is updated
//   busy          out  high in every state except IDLE
//   timeout_err   out  sticky: a decision was forced by timeout
// ---------------------------------------------------------------------------
module sar_cap_sequencer #(
    parameter int SAMPLE_CYCLES  = 4,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        samp_en,
    output logic        comp_start,
    input  logic        comp_valid,
    input  logic        comp_out,
    output logic [15:0] cap_botplate,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_COMP,
        S_WAIT,
        S_DONE
    } state_t;

    // One shared counter serves the sample, settle and wait phases, so it is
    // sized for the longest of them.
    localparam int MAX_CYC_01 = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC    = (MAX_CYC_01 > TIMEOUT_CYCLES) ? MAX_CYC_01 : TIMEOUT_CYCLES;
    localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;

    logic             timed_out;
    logic             decide;
    logic             decision;
    logic [15:0]      decided_bus;

    // Decision for the bit under test: the comparator answer, or a forced 0
    // once the wait budget for this bit is used up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        timed_out   = 1'b0;
        decide      = 1'b0;
        decision    = 1'b0;
        decided_bus = cap_botplate;
        if (state == S_WAIT) begin
            timed_out = !comp_valid && (cnt == TIMEOUT_LAST);
            decide    = comp_valid || timed_out;
            decision  = comp_valid && comp_out;
        end
        decided_bus[bit_idx] = decision;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the data path, is reset so all
            // outputs take known values the instant rst_n falls.
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= 4'd15;
            samp_en      <= 1'b0;
            comp_start   <= 1'b0;
            cap_botplate <= 16'h0000;
            result       <= 16'h0000;
            done         <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            comp_start <= 1'b0;
            done       <= 1'b0;

            if (abort && state != S_IDLE) begin
                // Result and timeout_err are deliberately left untouched.
                state        <= S_IDLE;
                cap_botplate <= 16'h0000;
                samp_en      <= 1'b0;
                busy         <= 1'b0;
                cnt          <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        cap_botplate <= 16'h0000;
                        if (start && !abort) begin
                            state       <= S_SAMPLE;
                            timeout_err <= 1'b0;
                            cnt         <= '0;
                            samp_en     <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end

                    S_SAMPLE: begin
                        if (cnt == SAMPLE_LAST) begin
                            samp_en      <= 1'b0;
                            cap_botplate <= 16'h8000;
                            bit_idx      <= 4'd15;
                            cnt          <= '0;
                            state        <= S_SETTLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            comp_start <= 1'b1;
                            cnt        <= '0;
                            state      <= S_COMP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    // The strobe is high during this state; any comp_valid
                    // seen here is stale and ignored.
                    S_COMP: begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (decide) begin
                            if (timed_out) begin
                                timeout_err <= 1'b1;
                            end
                            if (bit_idx != 4'd0) begin
                                // Commit bit i and raise trial bit i-1 on the same edge.
                                cap_botplate <= decided_bus | (16'h0001 << (bit_idx - 4'd1));
                                bit_idx      <= bit_idx - 4'd1;
                                cnt          <= '0;
                                state        <= S_SETTLE;
                            end else begin
                                cap_botplate <= decided_bus;
                                result       <= decided_bus;
                                done         <= 1'b1;
                                state        <= S_DONE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    // The final code stays on the bus for the done cycle and
                    // is cleared on the way back to IDLE.
                    S_DONE: begin
                        cap_botplate <= 16'h0000;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_cap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sar_cap_sequencer
//
// Self-checking bench for sar_cap_sequencer with default parameters. A
// comparator model answers each comp_start with bits of a chosen code after a
// chosen delay (or never). Expected codes, trial bus values and done timing
// are computed arithmetically from the conversion rules.
// ---------------------------------------------------------------------------
module tb_sar_cap_sequencer;

    localparam int SAMPLE  = 4;
    localparam int SETTLE  = 1;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        comp_valid = 1'b0;
    logic        comp_out = 1'b0;
    logic        samp_en;
    logic        comp_start;
    logic [15:0] cap_botplate;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        timeout_err;

    sar_cap_sequencer #(
        .SAMPLE_CYCLES (SAMPLE),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .samp_en     (samp_en),
        .comp_start  (comp_start),
        .comp_valid  (comp_valid),
        .comp_out    (comp_out),
        .cap_botplate(cap_botplate),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Comparator model and observation state.
    int          cyc;
    logic [15:0] pat;
    int          resp_delay;
    bit          silent;
    bit          resp_armed;
    int          resp_wait;
    int          resp_bit;
    int          cs_idx;
    int          done_count;
    int          done_cycle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Trial bus just before deciding bit b: decided upper bits plus bit b set.
    function automatic logic [15:0] trial_value(input logic [15:0] code, input int b);
        int upper;
        upper = (int'(code) / (1 << (b + 1))) * (1 << (b + 1));
        return 16'(upper + (1 << b));
    endfunction

    // Advance one cycle, sample outputs 1 ns after the edge, run the comparator model.
    task automatic tick();
        logic [15:0] eff;
        @(posedge clk);
        #1;
        cyc++;
        eff        = silent ? 16'h0000 : pat;
        comp_valid = 1'b0;
        comp_out   = 1'($urandom);
        if (resp_armed) begin
            if (resp_wait == 0) begin
                comp_valid = 1'b1;
                comp_out   = pat[resp_bit];
                resp_armed = 1'b0;
            end else begin
                resp_wait--;
            end
        end
        if (comp_start === 1'b1) begin
            if (cs_idx < 16) begin
                check($sformatf("trial_bit%0d", 15 - cs_idx), cap_botplate, trial_value(eff, 15 - cs_idx));
            end
            resp_bit = 15 - cs_idx;
            cs_idx++;
            if (!silent) begin
                resp_armed = 1'b1;
                resp_wait  = resp_delay;
            end
        end
        if (done === 1'b1) begin
            done_count++;
            done_cycle = cyc;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_samp_en"}, samp_en, 0);
        check({tag, "_comp_start"}, comp_start, 0);
        check({tag, "_cap"}, cap_botplate, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // One conversion. abort_at / reset_at (0 = unused) interrupt it in that cycle;
    // poke drives start pulses while busy and during the done cycle.
    task automatic convert(input logic [15:0] p, input int dly, input bit sil,
                           input int abort_at, input int reset_at, input bit poke);
        int w;
        int exp_done;
        pat        = p;
        resp_delay = dly;
        silent     = sil;
        cs_idx     = 0;
        resp_armed = 1'b0;
        done_count = 0;
        done_cycle = -1;
        cyc        = 0;
        w          = sil ? TIMEOUT : dly + 1;
        exp_done   = SAMPLE + 16 * (SETTLE + 1 + w) + 1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("samp_en_c1", samp_en, 1);
        check("busy_c1", busy, 1);
        check("timeout_err_cleared", timeout_err, 0);

        for (int k = 0; k < 400 && done_count == 0; k++) begin
            if (cyc == SAMPLE) check("samp_en_last", samp_en, 1);
            if (cyc == SAMPLE + 1) begin
                check("cap_first_trial", cap_botplate, 16'h8000);
                check("samp_en_off", samp_en, 0);
            end
            if (cyc == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_cap", cap_botplate, 0);
                check("abort_samp_en", samp_en, 0);
                repeat (12) tick();
                check("abort_no_done", done_count, 0);
                return;
            end
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("async_rst");
                resp_armed = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                return;
            end
            start = poke && (cyc % 7 == 3);
            tick();
        end

        check("done_seen", done_count, 1);
        if (!sil) check("done_cycle", done_cycle, exp_done);
        check("result", result, sil ? 16'h0000 : p);
        check("timeout_err_at_done", timeout_err, sil);
        check("busy_in_done", busy, 1);

        start = poke;
        tick();
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_cap", cap_botplate, 0);
        repeat (5) tick();
        check("single_done", done_count, 1);
        check("still_idle", busy, 0);
    endtask

    initial begin
        cyc = 0;
        silent = 1'b0;
        resp_armed = 1'b0;
        pat = 16'h0000;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed conversions.
        convert(16'hA5C3, 0, 1'b0, 0, 0, 1'b0);
        convert(16'h0000, 0, 1'b0, 0, 0, 1'b0);
        convert(16'hFFFF, 0, 1'b0, 0, 0, 1'b0);
        convert(16'hA5C3, 2, 1'b0, 0, 0, 1'b1);

        // Silent comparator, then confirm the sticky flag clears on the next start.
        convert(16'h5A5A, 0, 1'b1, 0, 0, 1'b0);
        convert(16'hA5C3, 0, 1'b0, 0, 0, 1'b0);

        // Abort mid-conversion keeps the previous result.
        convert(16'h1234, 0, 1'b0, 20, 0, 1'b0);
        check("abort_result_kept", result, 16'hA5C3);
        check("abort_timeout_err_kept", timeout_err, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_wins_busy", busy, 0);
        check("idle_abort_wins_samp", samp_en, 0);

        // Asynchronous reset mid-conversion, then a clean conversion.
        convert(16'h0F0F, 0, 1'b0, 0, 30, 1'b0);
        convert(16'h1234, 1, 1'b0, 0, 0, 1'b0);

        // Randomized conversions.
        for (int n = 0; n < 4; n++) begin
            convert(16'($urandom), int'($urandom_range(0, 3)), 1'b0, 0, 0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
